// File: rtl/int_mul_pipe_if.sv
// Request/response bundle between the execute stage and the pipelined multiplier.
// in_op carries the 4-bit alu_t encoding; master is the issuing stage, slave is the unit.
interface int_mul_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [XLEN-1:0]  in_rs1;
  logic [XLEN-1:0]  in_rs2;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;
  logic             busy;

  modport master (
    output in_valid, in_op, in_rs1, in_rs2, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_illegal, busy
  );

  modport slave (
    input  in_valid, in_op, in_rs1, in_rs2, in_tag, flush, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_illegal, busy
  );
endinterface

// File: rtl/int_mul_pipe.sv
// Pipelined RV32/RV64 M-extension multiplier (MUL/MULH/MULHU/MULHSU) with valid/ready,
// tag passthrough and flush. XLEN is 32 or 64, STAGES is 1..6.
module int_mul_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 3,
  parameter int TAG_W  = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  int_mul_pipe_if.slave  bus
);

  // alu_t encodings of the M-extension ops: bit 3 marks M, low bits are funct3.
  localparam logic [3:0] ALU_MUL    = 4'h8;
  localparam logic [3:0] ALU_MULH   = 4'h9;
  localparam logic [3:0] ALU_MULHSU = 4'hA;
  localparam logic [3:0] ALU_MULHU  = 4'hB;

  localparam logic [XLEN-1:0] ILLEGAL_WORD = {(XLEN/32){32'hDEADBEEF}};

  logic              w_adv;
  logic              w_fire;
  logic              w_legal;
  logic              w_sext_a;
  logic              w_sext_b;
  logic              w_sel_hi;
  logic [2*XLEN-1:0] w_opa;
  logic [2*XLEN-1:0] w_opb;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_res;

  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] r_illegal;
  logic [XLEN-1:0]   r_res [STAGES];
  logic [TAG_W-1:0]  r_tag [STAGES];

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    w_legal  = 1'b1;
    w_sext_a = 1'b0;
    w_sext_b = 1'b0;
    w_sel_hi = 1'b1;
    case (bus.in_op)
      ALU_MUL: begin
        w_sext_a = 1'b1;
        w_sext_b = 1'b1;
        w_sel_hi = 1'b0;
      end
      ALU_MULH: begin
        w_sext_a = 1'b1;
        w_sext_b = 1'b1;
      end
      ALU_MULHSU: w_sext_a = 1'b1;
      ALU_MULHU:  w_sext_a = 1'b0;
      default:    w_legal  = 1'b0;
    endcase
  end

  // Extending both operands to 2*XLEN makes one unsigned multiply correct modulo 2^(2*XLEN)
  // for every signedness mix; trailing stages give synthesis room to retime the array.
  assign w_opa  = {{XLEN{w_sext_a & bus.in_rs1[XLEN-1]}}, bus.in_rs1};
  assign w_opb  = {{XLEN{w_sext_b & bus.in_rs2[XLEN-1]}}, bus.in_rs2};
  assign w_prod = w_opa * w_opb;

  assign w_res = !w_legal ? ILLEGAL_WORD
               : w_sel_hi ? w_prod[2*XLEN-1:XLEN]
               :            w_prod[XLEN-1:0];

  assign w_adv  = !r_valid[STAGES-1] || bus.out_ready;
  assign w_fire = bus.in_valid && w_adv && !bus.flush;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    if (!rst_n) begin
      r_valid   <= '0;
      r_illegal <= '0;
      // NOTE: the data registers are reset too, since out_result and out_tag must read zero after reset.
      for (int k = 0; k < STAGES; k++) begin
        r_res[k] <= '0;
        r_tag[k] <= '0;
      end
    end else if (bus.flush) begin
      r_valid <= '0;
    end else if (w_adv) begin
      r_valid[0] <= w_fire;
      if (w_fire) begin
        r_res[0]     <= w_res;
        r_tag[0]     <= bus.in_tag;
        r_illegal[0] <= !w_legal;
      end
      for (int k = 1; k < STAGES; k++) begin
        r_valid[k]   <= r_valid[k-1];
        r_illegal[k] <= r_illegal[k-1];
        r_res[k]     <= r_res[k-1];
        r_tag[k]     <= r_tag[k-1];
      end
    end
  end

  assign bus.in_ready    = w_adv && !bus.flush;
  assign bus.out_valid   = r_valid[STAGES-1];
  assign bus.out_result  = r_res[STAGES-1];
  assign bus.out_tag     = r_tag[STAGES-1];
  assign bus.out_illegal = r_illegal[STAGES-1];
  assign bus.busy        = |r_valid;

endmodule
